// File: rtl/ddc_accumulator.sv
// ddc_accumulator: integrate-and-dump decimator for the DDC I/Q stream.
// Sums acc_len+1 valid samples per channel, scales by an arithmetic right
// shift and presents one {Q, I} word per frame on a ready/valid output.
// Frames that arrive while the output register is blocked are dropped and
// counted. Build option DDC_ACC_SATURATE_EN selects clamping of the scaled
// result (with a sticky overflow flag) instead of two's-complement wrap.
module ddc_accumulator #(
    parameter int IN_W  = 29,
    parameter int LEN_W = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [LEN_W-1:0] acc_len,
    input  logic [4:0]       shift,
    input  logic             valid_in,
    input  logic [63:0]      ddc_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [31:0]      frame_cnt,
    output logic [15:0]      drop_cnt,
    output logic             overflow
);

    // Wide enough to hold 2^LEN_W full-scale samples without wrapping.
    localparam int ACC_W = IN_W + LEN_W;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                   state;
    logic [LEN_W-1:0]         cnt;
    logic [LEN_W-1:0]         len_lat;
    logic [4:0]               shift_lat;

    logic signed [IN_W-1:0]   samp_i;
    logic signed [IN_W-1:0]   samp_q;
    logic signed [ACC_W-1:0]  ext_i;
    logic signed [ACC_W-1:0]  ext_q;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  frame_i;
    logic signed [ACC_W-1:0]  frame_q;

    logic                     first;
    logic                     take;
    logic                     last;
    logic [LEN_W-1:0]         len_eff;
    logic [4:0]               shift_eff;

    logic signed [ACC_W-1:0]  sum_i_p0;
    logic signed [ACC_W-1:0]  sum_q_p0;
    logic [4:0]               sh_p0;
    logic                     vld_p0;

    logic signed [ACC_W-1:0]  scaled_i;
    logic signed [ACC_W-1:0]  scaled_q;
    logic signed [OUT_W-1:0]  red_i;
    logic signed [OUT_W-1:0]  red_q;

    logic signed [OUT_W-1:0]  sc_i_p1;
    logic signed [OUT_W-1:0]  sc_q_p1;
    logic                     vld_p1;

    logic                     load;
    logic                     unused_bits;

    assign samp_i      = ddc_in[IN_W-1:0];
    assign samp_q      = ddc_in[32+IN_W-1:32];
    assign unused_bits = ^{ddc_in[63:32+IN_W], ddc_in[31:IN_W]};

    assign ext_i = {{LEN_W{samp_i[IN_W-1]}}, samp_i};
    assign ext_q = {{LEN_W{samp_q[IN_W-1]}}, samp_q};

    // A zero count marks the first sample of a frame: that sample loads the
    // accumulator and supplies the frame's length and shift, so a frame of
    // one sample (acc_len = 0) must already use the live inputs.
    assign first     = (cnt == '0);
    assign len_eff   = first ? acc_len : len_lat;
    assign shift_eff = first ? shift : shift_lat;
    assign take      = (state == ACCUM) && enable && valid_in;
    assign last      = take && (cnt == len_eff);
    assign frame_i   = first ? ext_i : acc_i + ext_i;
    assign frame_q   = first ? ext_q : acc_q + ext_q;

    assign scaled_i = sum_i_p0 >>> sh_p0;
    assign scaled_q = sum_q_p0 >>> sh_p0;

`ifdef DDC_ACC_SATURATE_EN
    function automatic logic is_clip(input logic signed [ACC_W-1:0] v);
        return !((&v[ACC_W-1:OUT_W-1]) || !(|v[ACC_W-1:OUT_W-1]));
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (!is_clip(v))
            return v[OUT_W-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return {1'b0, {(OUT_W-1){1'b1}}};
    endfunction

    assign red_i = sat_out(scaled_i);
    assign red_q = sat_out(scaled_q);

    // Sticky flag: any clamp on either channel since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (vld_p0 && (is_clip(scaled_i) || is_clip(scaled_q)))
            overflow <= 1'b1;
    end
`else
    logic unused_hi;

    assign red_i     = scaled_i[OUT_W-1:0];
    assign red_q     = scaled_q[OUT_W-1:0];
    assign unused_hi = ^{scaled_i[ACC_W-1:OUT_W], scaled_q[ACC_W-1:OUT_W]};
    assign overflow  = 1'b0;
`endif

    // The output register takes a new word when empty or emptying this cycle.
    assign load = vld_p1 && (!m_valid || m_ready);

    // Control path: run state, frame counter, latched settings, valid
    // pipeline, output handshake and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len_lat   <= '0;
            shift_lat <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable)
                        state <= ACCUM;
                end
                ACCUM: begin
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (take) begin
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (first) begin
                            len_lat   <= acc_len;
                            shift_lat <= shift;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // sum -> scale -> output stage boundaries
            vld_p0 <= last;
            vld_p1 <= vld_p0;

            if (load) begin
                m_valid <= 1'b1;
                m_data  <= {sc_q_p1, sc_i_p1};
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (m_valid && m_ready)
                frame_cnt <= frame_cnt + 32'd1;

            if (vld_p1 && !load && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Datapath: accumulators, frame sum (p0) and scaled result (p1).
    always_ff @(posedge clk) begin
        if ((state == ACCUM) && !enable) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (take) begin
            acc_i <= frame_i;
            acc_q <= frame_q;
        end

        if (last) begin
            sum_i_p0 <= frame_i;
            sum_q_p0 <= frame_q;
            sh_p0    <= shift_eff;
        end

        if (vld_p0) begin
            sc_i_p1 <= red_i;
            sc_q_p1 <= red_q;
        end
    end

endmodule

// File: tb/tb_ddc_accumulator.sv
// Testbench for ddc_accumulator: scoreboard of expected output words built
// from a behavioural frame model, compared as the DUT hands words over.
module tb_ddc_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] acc_len = '0;
    logic [4:0]  shift = '0;
    logic        valid_in = 1'b0;
    logic [63:0] ddc_in = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [63:0] m_data;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    ddc_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .acc_len  (acc_len),
        .shift    (shift),
        .valid_in (valid_in),
        .ddc_in   (ddc_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .frame_cnt(frame_cnt),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: expected word and expected load edge (-1 = not checked).
    logic [63:0] exp_q[$];
    int          lat_q[$];

    // Frame model state.
    longint m_acc_i = 0;
    longint m_acc_q = 0;
    int     m_cnt = 0;
    int     m_len = 0;
    int     m_sh = 0;
    bit     push_en = 1'b1;
    bit     lat_en = 1'b1;

    function automatic logic [31:0] reduce(input longint v);
        logic [63:0] t;
`ifdef DDC_ACC_SATURATE_EN
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
`endif
        t = v;
        return t[31:0];
    endfunction

    task automatic drive(input int i, input int q);
        logic [31:0] iv;
        logic [31:0] qv;
        iv = i;
        qv = q;
        ddc_in   = {3'b101, qv[28:0], 3'b010, iv[28:0]};
        valid_in = 1'b1;
        if (m_cnt == 0) begin
            m_len   = int'(acc_len);
            m_sh    = int'(shift);
            m_acc_i = i;
            m_acc_q = q;
        end else begin
            m_acc_i += i;
            m_acc_q += q;
        end
        @(posedge clk); #1;
        if (m_cnt == m_len) begin
            m_cnt = 0;
            if (push_en) begin
                exp_q.push_back({reduce(m_acc_q >>> m_sh), reduce(m_acc_i >>> m_sh)});
                lat_q.push_back(lat_en ? cyc + 2 : -1);
            end
        end else begin
            m_cnt++;
        end
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        valid_in = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_pending", exp_q.size(), 0);
        idle(2);
    endtask

    // Monitor: compare accepted words, check hold stability under stall.
    logic        hold_v = 1'b0;
    logic [63:0] hold_d = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && m_valid)
                chk("hold_stable", m_data, hold_d);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    logic [63:0] e;
                    int          l;
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    chk("word", m_data, e);
                    if (l >= 0)
                        chk("latency", cyc, l);
                end
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_overflow", overflow, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        idle(2);

        // N=4, shift 0, two frames of +1000/-1000
        acc_len = 16'd3;
        shift   = 5'd0;
        for (int k = 0; k < 8; k++) drive(1000, -1000);
        drain();
        chk("t1_frame_cnt", frame_cnt, 2);
        chk("t1_data", m_data, {32'hFFFFF060, 32'h00000FA0});

        // N=1, shift 1, ramp at full rate
        acc_len = 16'd0;
        shift   = 5'd1;
        for (int k = 0; k < 10; k++) drive(k, 0);
        drain();
        chk("t2_frame_cnt", frame_cnt, 12);
        chk("t2_last", m_data, 64'd4);

        // Back-pressure: first word held, four frames dropped
        shift   = 5'd0;
        m_ready = 1'b0;
        lat_en  = 1'b0;
        drive(1, -1);
        lat_en  = 1'b1;
        push_en = 1'b0;
        for (int k = 2; k <= 5; k++) drive(k, -k);
        push_en = 1'b1;
        idle(4);
        chk("t3_drop_cnt", drop_cnt, 4);
        chk("t3_m_valid", m_valid, 1);
        chk("t3_held", m_data, {32'hFFFFFFFF, 32'h00000001});
        m_ready = 1'b1;
        drain();
        chk("t3_frame_cnt", frame_cnt, 13);

        // Enable dropped mid-frame: partial frame discarded silently
        acc_len = 16'd3;
        drive(7, 3);
        drive(7, 3);
        valid_in = 1'b0;
        enable   = 1'b0;
        @(posedge clk); #1;
        m_cnt = 0;
        idle(1);
        enable = 1'b1;
        idle(2);
        for (int k = 0; k < 4; k++) drive(5, 0);
        drain();
        chk("t5_frame_cnt", frame_cnt, 14);
        chk("t5_data", m_data, 64'd20);
        chk("t5_drop_cnt", drop_cnt, 4);

        // Longest frame at positive full scale
        acc_len = 16'hFFFF;
        shift   = 5'd0;
        for (int k = 0; k < 65536; k++) drive(268435455, 0);
        drain();
        chk("t4_frame_cnt", frame_cnt, 15);
`ifdef DDC_ACC_SATURATE_EN
        chk("t4_data_i", m_data[31:0], 32'h7FFFFFFF);
        chk("t4_overflow", overflow, 1);
`else
        chk("t4_data_i", m_data[31:0], 32'hFFFF0000);
        chk("t4_overflow", overflow, 0);
`endif

        // Reset while a word is pending
        acc_len = 16'd3;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive(9, -2);
        idle(3);
        chk("t6_pending", m_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_m_valid", m_valid, 0);
        chk("t6_m_data", m_data, 0);
        chk("t6_frame_cnt", frame_cnt, 0);
        chk("t6_drop_cnt", drop_cnt, 0);
        chk("t6_overflow", overflow, 0);
        exp_q.delete();
        lat_q.delete();
        m_cnt = 0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        idle(2);
        for (int k = 0; k < 4; k++) drive(-3, 11);
        drain();
        chk("t6_frame_cnt_after", frame_cnt, 1);
        chk("t6_data_after", m_data, {32'h0000002C, 32'hFFFFFFF4});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddc_accumulator.md
# ddc_accumulator

Integrate-and-dump decimator placed directly downstream of the DDC core. It consumes the core's 64-bit valid-qualified I/Q stream and sums a programmable number of consecutive samples per channel. Each sum is scaled by a programmable right shift and emitted as one 64-bit I/Q word on a ready/valid output. It sets the output rate of the DAQ path and absorbs downstream back-pressure by dropping whole frames, with every drop counted.

## Interface
- `IN_W`, 29: signed width of each I/Q input component.
- `LEN_W`, 16: width of `acc_len`. Maximum frame length is 2^LEN_W samples. Accumulator width `ACC_W = IN_W + LEN_W` is derived and not overridable.
- `OUT_W`, 32: signed width of each output component.
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run control. Low clears the accumulation in progress.
- `acc_len` in LEN_W: frame length minus one, so N = acc_len+1 (range 1..65536).
- `shift` in 5: arithmetic right shift applied to each frame sum (0..31).
- `valid_in` in 1: input sample strobe from the DDC core.
- `ddc_in` in 64: Q = [60:32], I = [28:0], both signed. Bits [63:61] and [31:29] are ignored.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out 64: {Q[OUT_W-1:0], I[OUT_W-1:0]}, with Q in [63:32].
- `frame_cnt` out 32: frames accepted downstream. Wraps.
- `drop_cnt` out 16: frames discarded due to back-pressure. Saturates at 0xFFFF.
- `overflow` out 1: sticky saturation flag. Cleared only by reset.

## Operation
- States: IDLE (`enable` low) and ACCUM.
  - IDLE→ACCUM when `enable` is sampled high.
  - ACCUM→IDLE when `enable` is sampled low. Sample counter and accumulators clear on the same edge. The partial frame is discarded and not counted as dropped.
- `acc_len` and `shift` are latched on the first valid sample of each frame. Changes mid-frame take effect on the next frame.
- Per valid sample in ACCUM:
  - The first sample of a frame loads the accumulator: acc = sample, sign-extended to ACC_W.
  - Every other sample adds: acc += sample.
  - The sample counter increments.
- Last sample (count == latched acc_len):
  - acc + sample is written to the sum register.
  - The accumulator and counter restart, so the next valid sample begins a new frame with no bubble.
- Scale stage: sum >>> latched shift (arithmetic, truncating toward −∞), then reduced to OUT_W per channel as set by the Configuration macro.
- Output register:
  - Loaded when it is empty or is being accepted in the same cycle (`m_valid && m_ready`).
  - Otherwise the new frame is dropped and `drop_cnt` increments.
  - `frame_cnt` increments on each `m_valid && m_ready`.
- AXI-stream rules:
  - Once `m_valid` is high, `m_data` is held stable until accepted.
  - `m_valid` never depends combinationally on `m_ready`.
- Frames already in the sum or output register are still delivered after `enable` falls.

## Timing
- All outputs reset to 0: `m_valid`, `m_data`, `frame_cnt`, `drop_cnt`, `overflow`. The state machine resets to IDLE.
- Throughput: one input sample per clock, sustained.
- Latency: with edge T sampling the last sample, the sum is registered at T, scaled at T+1, and `m_valid` is high after edge T+2.
- N = 1 (`acc_len = 0`): every sample is a complete frame. Full rate is sustained when `m_ready` is held high.
- Reset asserted mid-frame or mid-handshake clears everything immediately. There is no partial output after reset.
- Simultaneous accept and new result in the same cycle: the new word loads, `m_valid` stays high, and no drop occurs.

## Configuration
- `DDC_ACC_SATURATE_EN` defined:
  - A scaled value outside the OUT_W signed range clamps to +2^(OUT_W-1)-1 or −2^(OUT_W-1).
  - `overflow` is set on any clamp.
- Not defined:
  - Scaled values are truncated to the low OUT_W bits (two's-complement wrap).
  - `overflow` is tied to 0.

## Test plan
- `acc_len`=3, `shift`=0, I=1000, Q=−1000 on 8 consecutive samples, `m_ready`=1 → two words with I=4000, Q=−4000. Each `m_valid` is high 2 edges after the 4th sample; `frame_cnt`=2.
- `acc_len`=0, `shift`=1, I ramping 0..9 every cycle → 10 consecutive words with I = 0,0,1,1,2,2,3,3,4,4 and no bubbles.
- `acc_len`=0, continuous input, `m_ready`=0 for 5 cycles → the first word is held stable, the 4 following frames are dropped, and `drop_cnt`=4.
- `acc_len`=65535, `shift`=0, I=+2^28−1 for every sample → with the macro: I=0x7FFFFFFF and `overflow`=1; without the macro: I = low 32 bits of the sum and `overflow`=0.
- `enable` dropped after 2 of 4 samples, then raised again with 4 samples of I=5 → one word only, I=20.
- `rst_n` pulsed low while `m_valid`=1 → all outputs 0 immediately; the next full frame produces a correct sum.
